// File: rtl/servo_pkg.sv
// servo_pkg: constants shared by the servo PWM bank and its channels.
// latency: n/a (constants and a helper function only).
// backpressure: n/a.
package servo_pkg;

   // Width of the shared frame counter; PERIOD must fit in it.
   localparam int CNT_W = 12;

   // Register offsets relative to BASE_ADDRESS. TARGET[i] lives at
   // TARGET_OFS + i; the control registers follow the channel block, so
   // their offsets are added to NUM_CHANNELS via ctrl_ofs().
   localparam int TARGET_OFS    = 0;
   localparam int ENABLE_OFS    = 0;
   localparam int SLEW_OFS      = 1;
   localparam int STATUS_OFS    = 2;
   localparam int NUM_CTRL_REGS = 3;

   function automatic logic [7:0] ctrl_ofs(input int num_channels, input int ofs);
      return 8'(num_channels + ofs);
   endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one PWM output holding TARGET, CURRENT, enable latch and slew step.
// latency: pin is registered, 1 clk after the counter compare; position moves only at frame boundaries.
// backpressure: none; TARGET writes are always accepted.
module servo_channel
   import servo_pkg::*;
#(
   parameter int MIN_PULSE = 110
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             boundary,
   input  logic             wr,
   input  logic [7:0]       din,
   input  logic             enable,
   input  logic [7:0]       slew,
   input  logic [CNT_W-1:0] cnt,
   output logic [7:0]       target,
   output logic             busy,
   output logic             pin
);

   localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);

   logic [7:0]       current;
   logic             en_latch;
   logic             up;
   logic [8:0]       diff;
   logic [7:0]       step;
   logic [7:0]       next_current;
   logic [CNT_W-1:0] pulse_end;

   // Requested position, written straight from the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         target <= '0;
      else if (wr)
         target <= din;
   end

   // Slew step: 9-bit distance, clamped to SLEW so CURRENT never overshoots.
   always_comb begin
      up   = 1'b1;
      diff = '0;
      step = '0;
      if (target >= current) begin
         diff = {1'b0, target} - {1'b0, current};
      end else begin
         up   = 1'b0;
         diff = {1'b0, current} - {1'b0, target};
      end
      if ((slew == 8'd0) || ({1'b0, slew} >= diff))
         step = diff[7:0];
      else
         step = slew;
      next_current = up ? (current + step) : (current - step);
   end

   // Position and enable only change at the frame boundary, so pulses are never cut or stretched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         current  <= '0;
         en_latch <= 1'b0;
      end else if (boundary) begin
         current  <= next_current;
         en_latch <= enable;
      end
   end

   assign pulse_end = MIN_W + CNT_W'(current);

   // Pin compare against the shared frame counter; reset drops the pin immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pin <= 1'b0;
      else
         pin <= en_latch && (cnt < pulse_end);
   end

   assign busy = (current != target) || (en_latch != enable);

endmodule

// File: rtl/servo_bank.sv
// servo_bank: NUM_CHANNELS hobby-servo PWM outputs sharing one prescaler and frame counter.
// latency: register writes take effect on the write edge, pins follow at the next frame boundary; reads return 1 clk after r_en.
// backpressure: none; the bus is always ready, writes to STATUS and unmapped addresses are dropped.
module servo_bank
   import servo_pkg::*;
#(
   parameter int         NUM_CHANNELS = 4,
   parameter logic [7:0] BASE_ADDRESS = 8'h00,
   parameter int         PRESCALE     = 95,
   parameter int         PERIOD       = 3405,
   parameter int         MIN_PULSE    = 110
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              din,
   input  logic [7:0]              address,
   input  logic                    w_en,
   input  logic                    r_en,
   output logic [7:0]              dout,
   output logic [NUM_CHANNELS-1:0] servo_pin
);

   localparam int         PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [7:0] ENABLE_A = ctrl_ofs(NUM_CHANNELS, ENABLE_OFS);
   localparam logic [7:0] SLEW_A   = ctrl_ofs(NUM_CHANNELS, SLEW_OFS);
   localparam logic [7:0] STATUS_A = ctrl_ofs(NUM_CHANNELS, STATUS_OFS);

   if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_chk_channels
      $error("servo_bank: NUM_CHANNELS must be 1..8");
   end
   if (PERIOD <= MIN_PULSE + 255) begin : g_chk_period_min
      $error("servo_bank: PERIOD must exceed MIN_PULSE + 255");
   end
   if (PERIOD > (1 << CNT_W)) begin : g_chk_period_max
      $error("servo_bank: PERIOD must fit the frame counter");
   end
   if (NUM_CHANNELS + NUM_CTRL_REGS > 256 - int'(BASE_ADDRESS)) begin : g_chk_map
      $error("servo_bank: register map does not fit above BASE_ADDRESS");
   end

   logic [PRE_W-1:0]        pre;
   logic                    pre_wrap;
   logic                    boundary;
   logic [CNT_W-1:0]        cnt;
   logic [7:0]              ofs;
   logic [NUM_CHANNELS-1:0] enable_reg;
   logic [7:0]              slew_reg;
   logic [7:0]              target [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] busy;
   logic [7:0]              rd_val;

   // Addresses below BASE_ADDRESS wrap to large offsets and so decode as unmapped.
   assign ofs      = address - BASE_ADDRESS;
   assign pre_wrap = (pre == PRE_W'(PRESCALE - 1));
   assign boundary = pre_wrap && (cnt == CNT_W'(PERIOD - 1));

   // Prescaler: divides clk down to frame-counter ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pre <= '0;
      else if (pre_wrap)
         pre <= '0;
      else
         pre <= pre + 1'b1;
   end

   // Frame counter: 0..PERIOD-1, wrapping on the boundary tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (boundary)
         cnt <= '0;
      else if (pre_wrap)
         cnt <= cnt + 1'b1;
   end

   // Shared control registers; only the implemented ENABLE bits are stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_reg <= '0;
         slew_reg   <= '0;
      end else if (w_en) begin
         if (ofs == ENABLE_A)
            enable_reg <= din[NUM_CHANNELS-1:0];
         if (ofs == SLEW_A)
            slew_reg <= din;
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      servo_channel #(
         .MIN_PULSE (MIN_PULSE)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .boundary (boundary),
         .wr       (w_en && (ofs == 8'(TARGET_OFS + i))),
         .din      (din),
         .enable   (enable_reg[i]),
         .slew     (slew_reg),
         .cnt      (cnt),
         .target   (target[i]),
         .busy     (busy[i]),
         .pin      (servo_pin[i])
      );
   end

   // Read mux; anything not in the map reads as 0.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (ofs == 8'(TARGET_OFS + i))
            rd_val = target[i];
      end
      if (ofs == ENABLE_A)
         rd_val[NUM_CHANNELS-1:0] = enable_reg;
      if (ofs == SLEW_A)
         rd_val = slew_reg;
      if (ofs == STATUS_A)
         rd_val[NUM_CHANNELS-1:0] = busy;
   end

   // Registered read data; samples pre-write values when a write hits the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dout <= '0;
      else
         dout <= r_en ? rd_val : 8'h00;
   end

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: directed plus randomized bench for servo_bank against a frame-level model.
// latency: n/a (bench).
// backpressure: n/a (bench).
module tb_servo_bank;

   localparam int         NCH  = 4;
   localparam logic [7:0] BASE = 8'h10;
   localparam int         PRE  = 3;
   localparam int         PER  = 370;
   localparam int         MINP = 110;
   localparam int         F    = PRE * PER;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     din = '0;
   logic [7:0]     address = '0;
   logic           w_en = 1'b0;
   logic           r_en = 1'b0;
   logic [7:0]     dout;
   logic [NCH-1:0] servo_pin;

   servo_bank #(
      .NUM_CHANNELS (NCH),
      .BASE_ADDRESS (BASE),
      .PRESCALE     (PRE),
      .PERIOD       (PER),
      .MIN_PULSE    (MINP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .address   (address),
      .w_en      (w_en),
      .r_en      (r_en),
      .dout      (dout),
      .servo_pin (servo_pin)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: register contents plus the per-frame latched state.
   int m_tgt [NCH];
   int m_cur [NCH];
   int m_en  [NCH];
   int m_ena;
   int m_slew;
   int cyc;

   // Per-frame observations.
   int             hi      [NCH];
   int             first_p [NCH];
   int             rises   [NCH];
   int             last_hi [NCH];
   int             bad_cyc;
   logic [NCH-1:0] prev_pin;
   int             slew_tab [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_tgt[i] = 0; m_cur[i] = 0; m_en[i] = 0;
         hi[i] = 0; first_p[i] = -1; rises[i] = 0; last_hi[i] = 0;
      end
      m_ena = 0; m_slew = 0; cyc = 0; bad_cyc = 0; prev_pin = '0;
   endtask

   task automatic model_write(input logic [7:0] a, input int val);
      int o;
      o = int'(a) - int'(BASE);
      if (o >= 0 && o < NCH) m_tgt[o] = val;
      else if (o == NCH)     m_ena = val & ((1 << NCH) - 1);
      else if (o == NCH + 1) m_slew = val;
   endtask

   function automatic int model_reg(input logic [7:0] a);
      int o;
      int s;
      o = int'(a) - int'(BASE);
      s = 0;
      if (o < 0) return 0;
      if (o < NCH) return m_tgt[o];
      if (o == NCH) return m_ena;
      if (o == NCH + 1) return m_slew;
      if (o == NCH + 2) begin
         for (int i = 0; i < NCH; i++)
            if (m_cur[i] != m_tgt[i] || m_en[i] != ((m_ena >> i) & 1)) s |= (1 << i);
         return s;
      end
      return 0;
   endfunction

   // Frame boundary: latch enables and move each position toward its target.
   task automatic model_boundary();
      int d;
      for (int i = 0; i < NCH; i++) begin
         m_en[i] = (m_ena >> i) & 1;
         d = m_tgt[i] - m_cur[i];
         if (m_slew == 0 || (d <= m_slew && -d <= m_slew)) m_cur[i] = m_tgt[i];
         else if (d > 0) m_cur[i] = m_cur[i] + m_slew;
         else m_cur[i] = m_cur[i] - m_slew;
      end
   endtask

   // Expected pins for frame position p (clk cycles into the frame).
   function automatic logic [NCH-1:0] exp_pins(input int p);
      logic [NCH-1:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i] = (m_en[i] != 0) && ((p / PRE) < MINP + m_cur[i]);
      return v;
   endfunction

   task automatic end_frame();
      int ew;
      chk("frame_trace_bad_cycles", bad_cyc, 0);
      for (int i = 0; i < NCH; i++) begin
         ew = (m_en[i] != 0) ? (MINP + m_cur[i]) * PRE : 0;
         chk($sformatf("frame_width_ch%0d", i), hi[i], ew);
         chk($sformatf("frame_rise_pos_ch%0d", i), first_p[i], (m_en[i] != 0) ? 0 : -1);
         chk($sformatf("frame_rises_ch%0d", i), rises[i], (m_en[i] != 0) ? 1 : 0);
         last_hi[i] = hi[i];
         hi[i] = 0; first_p[i] = -1; rises[i] = 0;
      end
      bad_cyc = 0;
      model_boundary();
   endtask

   // One clock: sample #1 after the edge, compare against the model trace.
   task automatic tick();
      int p;
      @(posedge clk);
      #1;
      cyc++;
      p = (cyc - 1) % F;
      if (servo_pin !== exp_pins(p)) bad_cyc++;
      for (int i = 0; i < NCH; i++) begin
         if (servo_pin[i] === 1'b1) begin
            hi[i]++;
            if (first_p[i] < 0) first_p[i] = p;
            if (prev_pin[i] !== 1'b1) rises[i]++;
         end
      end
      prev_pin = servo_pin;
      if (cyc % F == 0) end_frame();
   endtask

   task automatic goto_pos(input int p);
      for (int k = 0; k <= F && (cyc % F) != p; k++) tick();
   endtask

   task automatic finish_frame();
      tick();
      goto_pos(0);
   endtask

   task automatic wr(input logic [7:0] a, input int val);
      address = a; din = 8'(val); w_en = 1'b1;
      tick();
      w_en = 1'b0;
      model_write(a, val);
   endtask

   task automatic rd(input string tag, input logic [7:0] a);
      int e;
      e = model_reg(a);
      address = a; r_en = 1'b1;
      tick();
      r_en = 1'b0;
      chk(tag, dout, e);
   endtask

   task automatic rdwr(input string tag, input logic [7:0] a, input int val);
      int e;
      e = model_reg(a);
      address = a; din = 8'(val); r_en = 1'b1; w_en = 1'b1;
      tick();
      r_en = 1'b0; w_en = 1'b0;
      chk(tag, dout, e);
      model_write(a, val);
   endtask

   // Reset asserted between edges; pins must drop before the next edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_pin_async", servo_pin, 0);
      @(posedge clk); #1;
      chk("rst_dout", dout, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      model_reset();
      slew_tab[0] = 120; slew_tab[1] = 130; slew_tab[2] = 135; slew_tab[3] = 135;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pin", servo_pin, 0);
      chk("reset_dout", dout, 0);
      rst = 1'b0;
      rd("reset_status", BASE + 8'(NCH + 2));
      rd("reset_target0", BASE);
      rd("reset_enable", BASE + 8'(NCH));

      // Basic pulse on channel 0
      wr(BASE, 100);
      wr(BASE + 8'(NCH), 1);
      wr(BASE + 8'(NCH + 1), 0);
      finish_frame();
      finish_frame();
      chk("basic_width_ch0", last_hi[0], 210 * PRE);
      chk("basic_width_ch1", last_hi[1], 0);
      finish_frame();
      chk("basic_width_ch0_again", last_hi[0], 210 * PRE);

      // Reset mid-pulse
      goto_pos(60);
      chk("pin_before_rst", servo_pin[0], 1);
      do_reset();
      rd("post_rst_status", BASE + 8'(NCH + 2));
      rd("post_rst_target0", BASE);

      // Slew on channel 1
      wr(BASE + 8'd1, 25);
      wr(BASE + 8'(NCH + 1), 10);
      wr(BASE + 8'(NCH), 3);
      finish_frame();
      for (int k = 0; k < 4; k++) begin
         finish_frame();
         chk($sformatf("slew_width_frame%0d", k), last_hi[1], slew_tab[k] * PRE);
         address = BASE + 8'(NCH + 2); r_en = 1'b1;
         tick();
         r_en = 1'b0;
         chk($sformatf("slew_status_bit1_frame%0d", k), dout[1], (k + 2 < 3) ? 1 : 0);
      end

      // Mid-frame TARGET change
      wr(BASE + 8'(NCH + 1), 0);
      finish_frame();
      goto_pos(60);
      chk("midwrite_pin_high", servo_pin[0], 1);
      wr(BASE, 255);
      finish_frame();
      chk("midwrite_current_pulse", last_hi[0], 110 * PRE);
      finish_frame();
      chk("midwrite_next_pulse", last_hi[0], 365 * PRE);

      // Bus decode
      wr(BASE + 8'(NCH + 2), 8'hFF);
      rd("status_after_write", BASE + 8'(NCH + 2));
      wr(BASE + 8'(NCH), 8'hFF);
      rd("enable_masked", BASE + 8'(NCH));
      chk("enable_masked_const", dout, 8'h0F);
      rd("unmapped_below_base", 8'h05);
      rd("unmapped_above_map", BASE + 8'(NCH + 3));
      rd("unmapped_top", 8'hFF);
      wr(BASE + 8'd2, 33);
      rd("target2_readback", BASE + 8'd2);
      tick();
      chk("dout_idle_zero", dout, 0);
      rdwr("rw_same_old_value", BASE + 8'd2, 77);
      chk("rw_same_old_const", dout, 33);
      rd("target2_new_value", BASE + 8'd2);

      // Enable toggle mid-pulse
      finish_frame();
      goto_pos(100);
      chk("entoggle_pin_high", servo_pin[0], 1);
      wr(BASE + 8'(NCH), 8'h0E);
      finish_frame();
      chk("entoggle_pulse_completes", last_hi[0], 365 * PRE);
      finish_frame();
      chk("entoggle_disabled", last_hi[0], 0);

      // Randomized traffic
      for (int f = 0; f < 8; f++) begin
         for (int w = 0; w < 3; w++) begin
            repeat ($urandom_range(20, 300)) tick();
            op = $urandom_range(0, 3);
            case (op)
               0: wr(BASE + 8'($urandom_range(0, NCH - 1)), $urandom_range(0, 255));
               1: wr(BASE + 8'(NCH), $urandom_range(0, 255));
               2: wr(BASE + 8'(NCH + 1), $urandom_range(0, 40));
               default: rd("random_read", BASE + 8'($urandom_range(0, NCH + 3)));
            endcase
         end
         finish_frame();
      end
      rd("final_status", BASE + 8'(NCH + 2));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
